// File: rtl/fp32_pkg.sv
// fp32_pkg: binary32 format constants, operand struct, divider FSM states and unpack helper
package fp32_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS = 127;
  localparam int QBITS = 26;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [FRAC_W:0] mant;
  } fp32_t;
  typedef enum logic [1:0] {LOAD, DIV, ROUND, DONE} state_t;
  function automatic fp32_t unpack(input logic [31:0] x);
    return '{sign: x[31], exp: x[30:23], mant: {1'b1, x[22:0]}};
  endfunction
endpackage

// File: rtl/chiabonus_mant_div.sv
// chiabonus_mant_div: bit-serial restoring mantissa divider, 26 quotient bits; ports clk/rst, start loads ma/mb, q/sticky result, done marks the final iteration
module chiabonus_mant_div
  import fp32_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FRAC_W:0]   ma,
  input  logic [FRAC_W:0]   mb,
  output logic [QBITS-1:0]  q,
  output logic              sticky,
  output logic              done
);
  logic [FRAC_W+1:0] rem, nrem;
  logic [FRAC_W:0] d;
  logic [FRAC_W+2:0] diff;
  logic [4:0] cnt;
  logic ge;
  always_comb begin
    diff = {1'b0, rem} - {2'b0, d};
    ge = ~diff[FRAC_W+2];
    nrem = ge ? diff[FRAC_W+1:0] : rem;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
      d <= '0;
      q <= '0;
      cnt <= '0;
    end else if (start) begin
      rem <= {1'b0, ma};
      d <= mb;
      q <= '0;
      cnt <= 5'(QBITS);
    end else if (cnt != 0) begin
      rem <= nrem << 1;
      q <= {q[QBITS-2:0], ge};
      cnt <= cnt - 5'd1;
    end
  end
  assign sticky = |rem;
  // high during the last step so the caller can leave DIV with q complete on the next edge
  assign done = cnt == 5'd1;
endmodule

// File: rtl/chiabonus.sv
// chiabonus: multi-cycle binary32 divider out = A / B with RNE rounding; ports clk/rst, A/B operands, registered out/underflow/overflow
module chiabonus
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] out,
  output logic        underflow,
  output logic        overflow
);
  state_t state, nstate;
  fp32_t ua, ub;
  logic [31:0] la, lb, res, res_c;
  logic [9:0] e, en;
  logic [QBITS-1:0] q;
  logic [FRAC_W-1:0] f, fr;
  logic sign, changed, load, sticky, dv_done, g, rb, up, c, of_c, uf_c, res_uf, res_of;
  always_comb begin
    ua = unpack(A);
    ub = unpack(B);
    changed = (A != la) || (B != lb);
    // an operand change restarts at once: this cycle acts as LOAD
    load = (state == LOAD) || changed;
    nstate = load ? DIV : state == DIV ? (dv_done ? ROUND : DIV) : state == ROUND ? DONE : LOAD;
    f = q[QBITS-1] ? q[24:2] : q[23:1];
    g = q[QBITS-1] ? q[1] : q[0];
    rb = q[QBITS-1] & q[0];
    up = g & (rb | sticky | f[0]);
    {c, fr} = {1'b0, f} + {{FRAC_W{1'b0}}, up};
    en = e + {9'b0, c} - {9'b0, ~q[QBITS-1]};
    of_c = $signed(en) > 10'sd254;
    uf_c = $signed(en) < 10'sd1;
    res_c = of_c ? {sign, 8'hFF, 23'h0} : uf_c ? {sign, 31'h0} : {sign, en[7:0], fr};
  end
  chiabonus_mant_div u_div (
    .clk(clk), .rst(rst), .start(load), .ma(ua.mant), .mb(ub.mant),
    .q(q), .sticky(sticky), .done(dv_done)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      la <= '0;
      lb <= '0;
      sign <= 1'b0;
      e <= '0;
      res <= '0;
      res_uf <= 1'b0;
      res_of <= 1'b0;
      out <= '0;
      underflow <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= nstate;
      if (load) begin
        la <= A;
        lb <= B;
        sign <= ua.sign ^ ub.sign;
        e <= {2'b0, ua.exp} - {2'b0, ub.exp} + 10'(BIAS);
      end
      if (state == ROUND) begin
        res <= res_c;
        res_uf <= uf_c;
        res_of <= of_c;
      end
      // a result for operands that just changed is stale and is dropped
      if (state == DONE && !changed) begin
        out <= res;
        underflow <= res_uf;
        overflow <= res_of;
      end
    end
  end
endmodule

// File: tb/tb_chiabonus.sv
// tb_chiabonus: directed scoreboard bench for the binary32 sequential divider
module tb_chiabonus;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] A = '0, B = '0, out;
  logic underflow, overflow;
  int checks = 0, errors = 0;
  logic [33:0] sb[$];
  logic [33:0] prev, exp_v;
  always #5 clk = ~clk;
  chiabonus dut (
    .clk(clk), .rst(rst), .A(A), .B(B),
    .out(out), .underflow(underflow), .overflow(overflow)
  );
  task automatic check(input string tag, input logic [33:0] want);
    checks++;
    assert ({out, underflow, overflow} === want)
      else begin
        errors++;
        $error("FAIL %s got out/uf/of=%h/%b/%b want %h/%b/%b", tag, out, underflow, overflow,
               want[33:2], want[1], want[0]);
      end
  endtask
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [33:0] want);
    sb.push_back(want);
    @(posedge clk);
    #1;
    A = a;
    B = b;
    repeat (28) @(posedge clk);
    #1;
    check({tag, "_hold"}, prev);
    @(posedge clk);
    #1;
    exp_v = sb.pop_front();
    check(tag, exp_v);
    prev = exp_v;
    repeat (11) @(posedge clk);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset", 34'h0);
    rst = 1'b0;
    prev = 34'h0;
    run("c1_pos", 32'h3F700000, 32'h3E300000, {32'h40AE8BA3, 2'b00});
    run("c2_neg2", 32'h3F500000, 32'hBED00000, {32'hC0000000, 2'b00});
    run("c3_norm", 32'h3F900000, 32'hBF500000, {32'hBFB13B14, 2'b00});
    run("c4_ovf", 32'h7F500000, 32'hBF400000, {32'hFF800000, 2'b01});
    run("c5_unf", 32'h00500000, 32'hC0500000, {32'h80000000, 2'b10});
    @(posedge clk);
    #1;
    A = 32'h3F700000;
    B = 32'h3E300000;
    sb.push_back({32'h40AE8BA3, 2'b00});
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst", 34'h0);
    rst = 1'b0;
    prev = 34'h0;
    repeat (28) @(posedge clk);
    #1;
    check("post_rst_hold", prev);
    @(posedge clk);
    #1;
    exp_v = sb.pop_front();
    check("post_rst", exp_v);
    prev = exp_v;
    @(posedge clk);
    #1;
    A = 32'h3F500000;
    B = 32'h3E300000;
    repeat (12) @(posedge clk);
    run("b_change", 32'h3F500000, 32'hBED00000, {32'hC0000000, 2'b00});
    checks++;
    assert (sb.size() == 0)
      else begin
        errors++;
        $error("FAIL sb_empty got %0d want 0", sb.size());
      end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
